// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer / rename definitions.
// Holds the tag, register-address and data widths, the reserved "no tag" value and the
// layout of one reorder-buffer entry. The rename map table imports the same package, so
// NO_TAG must stay defined here and nowhere else.
package reorder_buffer_pkg;

    localparam int unsigned ROB_TAG_LEN  = 4;
    localparam int unsigned REG_ADDR_LEN = 5;
    localparam int unsigned XLEN         = 32;

    // All-ones tag marks "no producer in flight"; never handed out as a real entry.
    localparam logic [ROB_TAG_LEN-1:0] NO_TAG = '1;

    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [XLEN-1:0]         value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions, committed in program order.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   dispatch_valid/_dest            rename stage asks for an entry for destination _dest
//   dispatch_ready, assign_rob_tag  an entry is free; the tag it will get (tail)
//   cdb_valid/_rob_tag/_value       completion broadcast, marks the tagged entry done
//   read_tag1/2, read_value1/2      operand reads of stored results (no CDB bypass)
//   return_flag                     head entry commits this cycle
//   reg_addr_from_rob               head destination register
//   rob_tag_from_rob                head tag
//   commit_value                    head result
//   flush                           squash every in-flight entry
//   count                           number of occupied entries
//
// Width parameters must match reorder_buffer_pkg, since entries use the shared
// rob_entry_t layout.
module reorder_buffer #(
    parameter int unsigned ROB_TAG_LEN  = reorder_buffer_pkg::ROB_TAG_LEN,
    parameter int unsigned ROB_SIZE     = 2 ** ROB_TAG_LEN - 1,
    parameter int unsigned REG_ADDR_LEN = reorder_buffer_pkg::REG_ADDR_LEN,
    parameter int unsigned XLEN         = reorder_buffer_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatch_valid,
    input  logic [REG_ADDR_LEN-1:0] dispatch_dest,
    output logic                    dispatch_ready,
    output logic [ROB_TAG_LEN-1:0]  assign_rob_tag,
    input  logic                    cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]  cdb_rob_tag,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic [ROB_TAG_LEN-1:0]  read_tag1,
    input  logic [ROB_TAG_LEN-1:0]  read_tag2,
    output logic [XLEN-1:0]         read_value1,
    output logic [XLEN-1:0]         read_value2,
    output logic                    return_flag,
    output logic [REG_ADDR_LEN-1:0] reg_addr_from_rob,
    output logic [ROB_TAG_LEN-1:0]  rob_tag_from_rob,
    output logic [XLEN-1:0]         commit_value,
    input  logic                    flush,
    output logic [ROB_TAG_LEN-1:0]  count
);

    import reorder_buffer_pkg::*;

    localparam logic [ROB_TAG_LEN-1:0] LAST_TAG = ROB_TAG_LEN'(ROB_SIZE - 1);
    localparam logic [ROB_TAG_LEN-1:0] FULL_CNT = ROB_TAG_LEN'(ROB_SIZE);

    // Pointers wrap at ROB_SIZE-1, so they never reach the reserved all-ones tag.
    function automatic logic [ROB_TAG_LEN-1:0] ptr_inc(input logic [ROB_TAG_LEN-1:0] ptr);
        return (ptr == LAST_TAG) ? '0 : ptr + 1'b1;
    endfunction

    rob_entry_t                r_entries [ROB_SIZE];
    logic [ROB_TAG_LEN-1:0]    r_head;
    logic [ROB_TAG_LEN-1:0]    r_tail;
    logic [ROB_TAG_LEN-1:0]    r_count;

    logic w_dispatch_fire;
    logic w_commit;
    logic w_cdb_hit;

    // Readiness looks at current occupancy only: a slot freed by this cycle's commit
    // is not reusable until the next cycle.
    assign dispatch_ready  = (r_count != FULL_CNT) && !flush;
    assign w_dispatch_fire = dispatch_valid && dispatch_ready;
    assign assign_rob_tag  = r_tail;

    // Head done bit is registered, so a CDB write to the head commits a cycle later.
    assign w_commit    = r_entries[r_head].valid && r_entries[r_head].done && !flush;
    assign return_flag = w_commit;

    assign reg_addr_from_rob = r_entries[r_head].dest;
    assign rob_tag_from_rob  = r_head;
    assign commit_value      = r_entries[r_head].value;

    assign w_cdb_hit = cdb_valid && (cdb_rob_tag != NO_TAG) && (cdb_rob_tag < FULL_CNT)
                       && r_entries[cdb_rob_tag].valid;

    assign read_value1 = (read_tag1 < FULL_CNT) ? r_entries[read_tag1].value : '0;
    assign read_value2 = (read_tag2 < FULL_CNT) ? r_entries[read_tag2].value : '0;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                r_entries[i] <= '0;
            end
        end else if (flush) begin
            // Squash only the status bits; stale dest/value are harmless once invalid.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                r_entries[i].valid <= 1'b0;
                r_entries[i].done  <= 1'b0;
            end
        end else begin
            if (w_cdb_hit) begin
                r_entries[cdb_rob_tag].done  <= 1'b1;
                r_entries[cdb_rob_tag].value <= cdb_value;
            end
            if (w_commit) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= ptr_inc(r_head);
            end
            // Tail is never the committing head here: dispatch needs a free slot,
            // commit needs an occupied one.
            if (w_dispatch_fire) begin
                r_entries[r_tail].valid <= 1'b1;
                r_entries[r_tail].done  <= 1'b0;
                r_entries[r_tail].dest  <= dispatch_dest;
                r_tail                  <= ptr_inc(r_tail);
            end
            case ({w_dispatch_fire, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    localparam int TL = 4;
    localparam int SZ = 15;
    localparam int AL = 5;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dispatch_valid = 1'b0;
    logic [AL-1:0] dispatch_dest = '0;
    logic          dispatch_ready;
    logic [TL-1:0] assign_rob_tag;
    logic          cdb_valid = 1'b0;
    logic [TL-1:0] cdb_rob_tag = '0;
    logic [XL-1:0] cdb_value = '0;
    logic [TL-1:0] read_tag1 = '0;
    logic [TL-1:0] read_tag2 = '0;
    logic [XL-1:0] read_value1;
    logic [XL-1:0] read_value2;
    logic          return_flag;
    logic [AL-1:0] reg_addr_from_rob;
    logic [TL-1:0] rob_tag_from_rob;
    logic [XL-1:0] commit_value;
    logic          flush = 1'b0;
    logic [TL-1:0] count;

    reorder_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .dispatch_valid    (dispatch_valid),
        .dispatch_dest     (dispatch_dest),
        .dispatch_ready    (dispatch_ready),
        .assign_rob_tag    (assign_rob_tag),
        .cdb_valid         (cdb_valid),
        .cdb_rob_tag       (cdb_rob_tag),
        .cdb_value         (cdb_value),
        .read_tag1         (read_tag1),
        .read_tag2         (read_tag2),
        .read_value1       (read_value1),
        .read_value2       (read_value2),
        .return_flag       (return_flag),
        .reg_addr_from_rob (reg_addr_from_rob),
        .rob_tag_from_rob  (rob_tag_from_rob),
        .commit_value      (commit_value),
        .flush             (flush),
        .count             (count)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of in-flight instructions plus the
    // last result written for each tag.
    typedef struct {
        int tag;
        int dest;
        bit done;
    } rec_t;

    rec_t          q[$];
    logic [XL-1:0] mval [SZ];
    int            m_tail;

    int n_tests = 0;
    int n_fail  = 0;
    int rd1 = 0;
    int rd2 = 1;

    logic          obs_ready;
    logic          obs_ret;
    logic [TL-1:0] obs_atag;
    logic [TL-1:0] obs_count;
    logic [TL-1:0] obs_rtag;
    logic [XL-1:0] obs_cval;
    logic [XL-1:0] obs_rv1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        for (int i = 0; i < SZ; i++) mval[i] = '0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance model.
    task automatic step(input bit dv, input int dd, input bit cv, input int ct,
                        input logic [XL-1:0] cval, input bit fl, input bit rst);
        bit e_ready;
        bit e_ret;
        @(negedge clk);
        dispatch_valid = dv;
        dispatch_dest  = AL'(dd);
        cdb_valid      = cv;
        cdb_rob_tag    = TL'(ct);
        cdb_value      = cval;
        flush          = fl;
        reset          = rst;
        read_tag1      = TL'(rd1);
        read_tag2      = TL'(rd2);
        #1;
        e_ready = (q.size() != SZ) && !fl;
        e_ret   = (q.size() != 0) && q[0].done && !fl;
        check("dispatch_ready", dispatch_ready, e_ready);
        check("assign_rob_tag", assign_rob_tag, m_tail);
        check("count", count, q.size());
        check("return_flag", return_flag, e_ret);
        if (e_ret) begin
            check("commit_dest", reg_addr_from_rob, q[0].dest);
            check("commit_tag", rob_tag_from_rob, q[0].tag);
            check("commit_value", commit_value, mval[q[0].tag]);
        end
        check("read_value1", read_value1, mval[rd1]);
        check("read_value2", read_value2, mval[rd2]);
        obs_ready = dispatch_ready;
        obs_ret   = return_flag;
        obs_atag  = assign_rob_tag;
        obs_count = count;
        obs_rtag  = rob_tag_from_rob;
        obs_cval  = commit_value;
        obs_rv1   = read_value1;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (cv && ct < SZ) begin
                foreach (q[k]) begin
                    if (q[k].tag == ct) begin
                        q[k].done = 1'b1;
                        mval[ct]  = cval;
                    end
                end
            end
            if (e_ret) void'(q.pop_front());
            if (dv && e_ready) begin
                q.push_back('{tag: m_tail, dest: dd, done: 1'b0});
                m_tail = (m_tail == SZ - 1) ? 0 : m_tail + 1;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, '0, 0, 1);
    endtask

    initial begin
        // Bring the DUT out of its unknown power-up state before any comparison.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Fill: 15 dispatches get tags 0..14, the 16th is refused.
        idle();
        check("reset_ready", obs_ready, 1);
        check("reset_tag", obs_atag, 0);
        check("reset_ret", obs_ret, 0);
        check("reset_count", obs_count, 0);
        for (int i = 1; i <= 15; i++) begin
            step(1, i, 0, 0, '0, 0, 0);
            check("fill_tag", obs_atag, i - 1);
        end
        step(1, 16, 0, 0, '0, 0, 0);
        check("full_ready", obs_ready, 0);
        check("full_count", obs_count, 15);
        idle();
        check("no_16th", obs_count, 15);

        // Full buffer: same-cycle commit does not admit a dispatch; tail has wrapped to 0.
        step(0, 0, 1, 0, 32'h1234_5678, 0, 0);
        step(1, 20, 0, 0, '0, 0, 0);
        check("full_commit_ret", obs_ret, 1);
        check("full_commit_ready", obs_ready, 0);
        step(1, 21, 0, 0, '0, 0, 0);
        check("wrap_ready", obs_ready, 1);
        check("wrap_tag", obs_atag, 0);
        check("wrap_count", obs_count, 14);
        idle();
        check("refill_count", obs_count, 15);

        // CDB to an invalid entry is ignored.
        do_reset();
        rd1 = 5;
        step(0, 0, 1, 5, 32'hdead_beef, 0, 0);
        idle();
        check("cdb_invalid_rv1", obs_rv1, 0);
        check("cdb_invalid_count", obs_count, 0);

        // Out-of-order completion, in-order commit.
        step(1, 3, 0, 0, '0, 0, 0);
        step(1, 4, 0, 0, '0, 0, 0);
        step(1, 5, 0, 0, '0, 0, 0);
        step(0, 0, 1, 1, 32'haaaa_0001, 0, 0);
        check("ooo_no_ret1", obs_ret, 0);
        step(0, 0, 1, 0, 32'hbbbb_0000, 0, 0);
        check("ooo_no_ret0", obs_ret, 0);
        idle();
        check("ooo_ret_a", obs_ret, 1);
        check("ooo_tag_a", obs_rtag, 0);
        check("ooo_val_a", obs_cval, 32'hbbbb_0000);
        idle();
        check("ooo_ret_b", obs_ret, 1);
        check("ooo_tag_b", obs_rtag, 1);
        check("ooo_val_b", obs_cval, 32'haaaa_0001);
        idle();
        check("ooo_tag2_stays", obs_ret, 0);
        check("ooo_count", obs_count, 1);

        // Flush with 6 occupied and a same-cycle dispatch.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, i + 7, 0, 0, '0, 0, 0);
        step(1, 9, 0, 0, '0, 1, 0);
        check("flush_ready", obs_ready, 0);
        idle();
        check("flush_count", obs_count, 0);
        check("flush_ret", obs_ret, 0);
        check("flush_tag", obs_atag, 0);

        // Reset mid-stream with 4 done entries: nothing commits afterward.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, i + 10, 0, 0, '0, 0, 0);
        for (int t = 3; t >= 0; t--) step(0, 0, 1, t, XL'(32'h100 + t), 0, 0);
        step(0, 0, 0, 0, '0, 0, 1);
        check("pre_reset_ret", obs_ret, 1);
        idle();
        check("post_reset_ret", obs_ret, 0);
        check("post_reset_count", obs_count, 0);
        check("post_reset_ready", obs_ready, 1);
        check("post_reset_tag", obs_atag, 0);
        idle();
        check("post_reset_ret2", obs_ret, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit dv;
            bit cv;
            int ct;
            dv  = ($urandom % 3) != 0;
            cv  = ($urandom % 2) != 0;
            ct  = (q.size() != 0 && ($urandom % 4) != 0) ? q[$urandom % q.size()].tag
                                                         : int'($urandom % 16);
            rd1 = int'($urandom % SZ);
            rd2 = int'($urandom % SZ);
            step(dv, int'($urandom % 32), cv, ct, $urandom, ($urandom % 60) == 0,
                 ($urandom % 300) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_TAG_LEN, default 4: tag width; the all-ones tag is reserved as "no tag".
REQ-002 Parameter ROB_SIZE, default 2**ROB_TAG_LEN-1 (15): entry count; tags 0..ROB_SIZE-1.
REQ-003 Parameter REG_ADDR_LEN, default 5; XLEN, default 32.
REQ-004 Clock and reset: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-005 dispatch_valid in 1: rename stage requests an entry.
REQ-006 dispatch_dest in REG_ADDR_LEN: architectural destination of the dispatching instruction.
REQ-007 dispatch_ready out 1: entry available this cycle.
REQ-008 assign_rob_tag out ROB_TAG_LEN: tag granted to the dispatching instruction.
REQ-009 cdb_valid in 1, cdb_rob_tag in ROB_TAG_LEN, cdb_value in XLEN: completion broadcast.
REQ-010 read_tag1 and read_tag2 in ROB_TAG_LEN; read_value1 and read_value2 out XLEN: operand read ports.
REQ-011 return_flag out 1, reg_addr_from_rob out REG_ADDR_LEN, rob_tag_from_rob out ROB_TAG_LEN, commit_value out XLEN: commit port.
REQ-012 flush in 1: squash all entries.
REQ-013 count out ROB_TAG_LEN: occupied entries.

Function
REQ-014 The block SHALL be a circular buffer with head (oldest), tail (next free) and count registers; each entry holds valid, done, dest and value.
REQ-015 dispatch_ready SHALL be (count != ROB_SIZE) && !flush, computed from current state only; a same-cycle commit does not free a slot for same-cycle dispatch.
REQ-016 assign_rob_tag SHALL equal tail combinationally.
REQ-017 Dispatch fires when dispatch_valid && dispatch_ready: at the edge, entry[tail] becomes valid=1, done=0, dest=dispatch_dest; tail advances.
REQ-018 tail and head SHALL wrap from ROB_SIZE-1 to 0 and never take the all-ones value.
REQ-019 On cdb_valid, if entry[cdb_rob_tag] is valid, the entry SHALL set done=1 and value=cdb_value at the edge; a CDB hit on an invalid entry or on the all-ones tag is ignored.
REQ-020 return_flag SHALL be entry[head].valid && entry[head].done && !flush, combinationally; reg_addr_from_rob, rob_tag_from_rob and commit_value SHALL present head's dest, head and value.
REQ-021 When return_flag=1, head SHALL advance and entry[head].valid SHALL clear at the edge: one commit per cycle.
REQ-022 A CDB write to the head entry SHALL commit no earlier than the following cycle, giving at least 1 cycle from CDB to commit.
REQ-023 When dispatch and commit occur in the same cycle, count SHALL remain unchanged; dispatch alone adds 1, commit alone subtracts 1.
REQ-024 read_valueN SHALL equal entry[read_tagN].value combinationally, with no CDB bypass; the consumer takes CDB data directly.
REQ-025 On flush, all valid and done bits SHALL clear, and head, tail and count SHALL return to 0 at the edge; flush overrides same-cycle dispatch, CDB and commit.
REQ-026 When the buffer is empty (count=0), return_flag SHALL be 0.

Reset
REQ-027 While reset is asserted at an edge, head, tail and count SHALL become 0 and every entry valid, done, dest and value SHALL become 0, regardless of in-flight activity.
REQ-028 After reset: dispatch_ready=1, assign_rob_tag=0, return_flag=0, count=0.

Structure
REQ-029 ROB_TAG_LEN, REG_ADDR_LEN, XLEN and the ROB_ENTRY typedef (valid, done, dest, value) SHALL live in the shared defs header used by the rename map table.
REQ-030 The no-tag constant (all-ones) SHALL be defined once in that header.
REQ-031 The design SHALL be a single module with no sub-module; the pointer wrap increment SHALL be a local function.

Verification
REQ-032 Reset, then 15 dispatches with dest=1..15 -> tags 0..14 granted, count=15, dispatch_ready=0; a 16th request is not accepted.
REQ-033 Dispatch tags 0,1,2; CDB tag 1 then tag 0 -> commit of tag 0 the cycle after its CDB, tag 1 the next cycle; tag 2 does not commit.
REQ-034 Run the buffer full, commit head and request dispatch in the same cycle -> no dispatch that cycle; dispatch accepted next cycle with tag 0 after tail wraps from 14.
REQ-035 CDB on tag 5 while entry 5 is invalid -> no state change; read_value1 for tag 5 unchanged.
REQ-036 Flush asserted with 6 entries occupied plus a same-cycle dispatch -> count=0, return_flag=0 and assign_rob_tag=0 next cycle.
REQ-037 Assert reset mid-stream with 4 entries done -> no commits afterward; post-reset values match REQ-028.
